// File: rtl/rx_preamble_strip.sv
// rx_preamble_strip: drops 0x55 preamble + 0xD5 SFD and emits frame bytes with sop/eop/error, rx_data cycle n -> stream_out cycle n+2.
// No backpressure: every beat is emitted unconditionally. `define STRICT_PREAMBLE_EN to require exactly seven preamble bytes.
module rx_preamble_strip #(
  parameter int DATA_WIDTH    = 8,
  parameter int MIN_PREAMBLE  = 1,
  parameter int MAX_FRAME_LEN = 1522
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_dv,
  input  logic                  rx_er,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  stream_out_startofpacket,
  output logic                  stream_out_endofpacket,
  output logic                  stream_out_valid,
  output logic [DATA_WIDTH-1:0] stream_out_data,
  output logic                  stream_out_error,
  output logic                  preamble_err
);

  localparam logic [DATA_WIDTH-1:0] PRE_BYTE = DATA_WIDTH'(8'h55);
  localparam logic [DATA_WIDTH-1:0] SFD_BYTE = DATA_WIDTH'(8'hD5);
  localparam logic [15:0]           MAX_LEN  = 16'(MAX_FRAME_LEN);
  localparam logic [3:0]            PRE_SAT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            pre_cnt_q, pre_cnt_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [DATA_WIDTH-1:0] hold_dat_q, hold_dat_d;
  logic                  sop_pend_q, sop_pend_d;
  logic                  sticky_err_q, sticky_err_d;
  logic [15:0]           len_cnt_q, len_cnt_d;

  logic                  out_vld_q, out_vld_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic                  out_err_q, out_err_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  pre_err_q, pre_err_d;

  logic                  sfd_ok_pre;
  logic                  sfd_ok_idle;

`ifdef STRICT_PREAMBLE_EN
  assign sfd_ok_pre  = (pre_cnt_q == 4'd7);
  assign sfd_ok_idle = 1'b0;
`else
  assign sfd_ok_pre  = ({28'd0, pre_cnt_q} >= 32'(MIN_PREAMBLE));
  assign sfd_ok_idle = (MIN_PREAMBLE == 0);
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    hold_vld_d   = hold_vld_q;
    hold_dat_d   = hold_dat_q;
    sop_pend_d   = sop_pend_q;
    sticky_err_d = sticky_err_q;
    len_cnt_d    = len_cnt_q;
    out_vld_d    = 1'b0;
    out_sop_d    = 1'b0;
    out_eop_d    = 1'b0;
    out_err_d    = 1'b0;
    out_dat_d    = '0;
    pre_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (rx_data == PRE_BYTE) begin
            state_d   = PRE;
            pre_cnt_d = 4'd1;
          end else if ((rx_data == SFD_BYTE) && sfd_ok_idle) begin
            state_d      = DATA;
            sop_pend_d   = 1'b1;
            len_cnt_d    = '0;
            hold_vld_d   = 1'b0;
            sticky_err_d = 1'b0;
          end else begin
            state_d   = DROP;
            pre_err_d = 1'b1;
          end
        end
      end

      PRE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_er) begin
          state_d   = DROP;
          pre_err_d = 1'b1;
        end else if (rx_data == PRE_BYTE) begin
          if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((rx_data == SFD_BYTE) && sfd_ok_pre) begin
          state_d      = DATA;
          sop_pend_d   = 1'b1;
          len_cnt_d    = '0;
          hold_vld_d   = 1'b0;
          sticky_err_d = 1'b0;
        end else begin
          state_d   = DROP;
          pre_err_d = 1'b1;
        end
      end

      DATA: begin
        // The held byte is only known to be last once dv drops or the length cap hits.
        if (!rx_dv) begin
          if (hold_vld_q) begin
            out_vld_d = 1'b1;
            out_dat_d = hold_dat_q;
            out_sop_d = sop_pend_q;
            out_eop_d = 1'b1;
            out_err_d = sticky_err_q;
          end
          hold_vld_d   = 1'b0;
          sticky_err_d = 1'b0;
          sop_pend_d   = 1'b0;
          state_d      = IDLE;
        end else if (len_cnt_q >= MAX_LEN) begin
          if (hold_vld_q) begin
            out_vld_d = 1'b1;
            out_dat_d = hold_dat_q;
            out_sop_d = sop_pend_q;
            out_eop_d = 1'b1;
            out_err_d = 1'b1;
          end
          hold_vld_d   = 1'b0;
          sticky_err_d = 1'b0;
          sop_pend_d   = 1'b0;
          state_d      = DROP;
        end else begin
          if (hold_vld_q) begin
            out_vld_d  = 1'b1;
            out_dat_d  = hold_dat_q;
            out_sop_d  = sop_pend_q;
            sop_pend_d = 1'b0;
          end
          hold_dat_d = rx_data;
          hold_vld_d = 1'b1;
          len_cnt_d  = len_cnt_q + 16'd1;
          if (rx_er) sticky_err_d = 1'b1;
        end
      end

      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end

      default: state_d = DROP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DROP;
      pre_cnt_q    <= '0;
      hold_vld_q   <= 1'b0;
      hold_dat_q   <= '0;
      sop_pend_q   <= 1'b0;
      sticky_err_q <= 1'b0;
      len_cnt_q    <= '0;
      out_vld_q    <= 1'b0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      out_err_q    <= 1'b0;
      out_dat_q    <= '0;
      pre_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      hold_vld_q   <= hold_vld_d;
      hold_dat_q   <= hold_dat_d;
      sop_pend_q   <= sop_pend_d;
      sticky_err_q <= sticky_err_d;
      len_cnt_q    <= len_cnt_d;
      out_vld_q    <= out_vld_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      out_err_q    <= out_err_d;
      out_dat_q    <= out_dat_d;
      pre_err_q    <= pre_err_d;
    end
  end

  assign stream_out_valid         = out_vld_q;
  assign stream_out_startofpacket = out_sop_q;
  assign stream_out_endofpacket   = out_eop_q;
  assign stream_out_error         = out_err_q;
  assign stream_out_data          = out_dat_q;
  assign preamble_err             = pre_err_q;

endmodule

// File: tb/tb_rx_preamble_strip.sv
// Directed bench for rx_preamble_strip: a default instance and a MAX_FRAME_LEN=16 instance share one stimulus stream;
// a negedge monitor logs emitted beats, and each test checks the log against hand-computed frames.
`timescale 1ns/1ps
module tb_rx_preamble_strip;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv, rx_er;
  logic [7:0] rx_data;

  logic       m_sop, m_eop, m_vld, m_err, m_pe;
  logic [7:0] m_dat;
  logic       s_sop, s_eop, s_vld, s_err, s_pe;
  logic [7:0] s_dat;

  rx_preamble_strip dut (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .stream_out_startofpacket(m_sop), .stream_out_endofpacket(m_eop),
    .stream_out_valid(m_vld), .stream_out_data(m_dat),
    .stream_out_error(m_err), .preamble_err(m_pe)
  );

  rx_preamble_strip #(.MAX_FRAME_LEN(16)) dut_short (
    .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rx_data(rx_data),
    .stream_out_startofpacket(s_sop), .stream_out_endofpacket(s_eop),
    .stream_out_valid(s_vld), .stream_out_data(s_dat),
    .stream_out_error(s_err), .preamble_err(s_pe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  dat;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  beat_t beats_m [0:2047];
  beat_t beats_s [0:2047];
  int    m_wr = 0, s_wr = 0, m_rd = 0, s_rd = 0;
  int    pe_m = 0, pe0 = 0, qual_bad = 0;
  int    n_cmp = 0, n_bad = 0;
  int    t_first = 0;
  beat_t bm, bs;

  always @(negedge clk) begin
    if (m_vld) begin
      bm.cyc = cyc; bm.dat = m_dat; bm.sop = m_sop; bm.eop = m_eop; bm.err = m_err;
      beats_m[m_wr] = bm;
      m_wr = m_wr + 1;
    end
    if (s_vld) begin
      bs.cyc = cyc; bs.dat = s_dat; bs.sop = s_sop; bs.eop = s_eop; bs.err = s_err;
      beats_s[s_wr] = bs;
      s_wr = s_wr + 1;
    end
    if (m_pe) pe_m = pe_m + 1;
    if (!m_vld && (m_sop || m_eop || m_err)) qual_bad = qual_bad + 1;
    if (!s_vld && (s_sop || s_eop || s_err)) qual_bad = qual_bad + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic dv, input logic er, input logic [7:0] d);
    rx_dv = dv; rx_er = er; rx_data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic mark();
    m_rd = m_wr; s_rd = s_wr; pe0 = pe_m;
  endtask

  task automatic send_frame(input int npre, input logic [7:0] first, input int len, input int er_idx);
    for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < len; i++) begin
      if (i == 0) t_first = cyc;
      step(1'b1, (i == er_idx), first + 8'(i));
    end
    step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic get_beat(input int sel, output beat_t b, output bit ok);
    b = '0; ok = 1'b0;
    if (sel == 0) begin
      if (m_rd < m_wr) begin b = beats_m[m_rd]; m_rd++; ok = 1'b1; end
    end else begin
      if (s_rd < s_wr) begin b = beats_s[s_rd]; s_rd++; ok = 1'b1; end
    end
  endtask

  // Frame of len consecutive bytes starting at first; error expected only on the eop beat.
  task automatic check_frame(input string tag, input int sel, input int len,
                             input logic [7:0] first, input logic exp_err);
    beat_t b;
    bit    ok;
    for (int i = 0; i < len; i++) begin
      get_beat(sel, b, ok);
      chk($sformatf("%s_avail%0d", tag, i), 32'(ok), 32'd1);
      if (!ok) break;
      chk($sformatf("%s_dat%0d", tag, i), 32'(b.dat), 32'(first + 8'(i)));
      chk($sformatf("%s_sop%0d", tag, i), 32'(b.sop), 32'(i == 0));
      chk($sformatf("%s_eop%0d", tag, i), 32'(b.eop), 32'(i == len - 1));
      chk($sformatf("%s_err%0d", tag, i), 32'(b.err), 32'((i == len - 1) && exp_err));
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 32'(m_vld), 32'd0);
    chk("rst_sop", 32'(m_sop), 32'd0);
    chk("rst_eop", 32'(m_eop), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_dat", 32'(m_dat), 32'd0);
    chk("rst_pe",  32'(m_pe),  32'd0);
    rst_n = 1'b1;
    idle(2);

    // 64-byte frame after a full preamble
    mark();
    send_frame(7, 8'h01, 64, -1);
    idle(3);
    chk("t1_beats", 32'(m_wr - m_rd), 32'd64);
    chk("t1_lat", beats_m[m_rd].cyc - 32'(t_first), 32'd2);
    check_frame("t1", 0, 64, 8'h01, 1'b0);
    chk("t1_pe", 32'(pe_m - pe0), 32'd0);

    // single-byte frame after a one-byte preamble
    mark();
    send_frame(1, 8'hAB, 1, -1);
    idle(3);
`ifdef STRICT_PREAMBLE_EN
    chk("t2_beats", 32'(m_wr - m_rd), 32'd0);
    chk("t2_pe", 32'(pe_m - pe0), 32'd1);
`else
    chk("t2_beats", 32'(m_wr - m_rd), 32'd1);
    check_frame("t2", 0, 1, 8'hAB, 1'b0);
    chk("t2_pe", 32'(pe_m - pe0), 32'd0);
`endif

    // rx_er on payload byte 10
    mark();
    send_frame(7, 8'h01, 64, 9);
    idle(3);
    chk("t3_beats", 32'(m_wr - m_rd), 32'd64);
    check_frame("t3", 0, 64, 8'h01, 1'b1);

    // bad preamble byte, one dv-low cycle, then a good frame
    mark();
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'h12);
    step(1'b0, 1'b0, 8'h00);
    send_frame(7, 8'h81, 8, -1);
    idle(3);
    chk("t4_pe", 32'(pe_m - pe0), 32'd1);
    chk("t4_beats", 32'(m_wr - m_rd), 32'd8);
    check_frame("t4", 0, 8, 8'h81, 1'b0);

    // back-to-back frames separated by one dv-low cycle
    mark();
    send_frame(7, 8'h21, 4, -1);
    send_frame(7, 8'h31, 4, -1);
    idle(3);
    chk("t4b_beats", 32'(m_wr - m_rd), 32'd8);
    check_frame("t4b_a", 0, 4, 8'h21, 1'b0);
    check_frame("t4b_b", 0, 4, 8'h31, 1'b0);

    // 20-byte frame into the 16-byte-limited instance
    mark();
    send_frame(7, 8'h41, 20, -1);
    idle(3);
    chk("t5_beats_s", 32'(s_wr - s_rd), 32'd16);
    check_frame("t5", 1, 16, 8'h41, 1'b1);
    chk("t5_beats_m", 32'(m_wr - m_rd), 32'd20);
    check_frame("t5m", 0, 20, 8'h41, 1'b0);
    mark();
    send_frame(7, 8'h61, 8, -1);
    idle(3);
    chk("t5n_beats_s", 32'(s_wr - s_rd), 32'd8);
    check_frame("t5n", 1, 8, 8'h61, 1'b0);

    // asynchronous reset mid-payload while dv stays high
    mark();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h01 + 8'(i));
    chk("t6_pre_beats", 32'(m_wr - m_rd), 32'd8);
    chk("t6_vld_before", 32'(m_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_vld_rst", 32'(m_vld), 32'd0);
    chk("t6_dat_rst", 32'(m_dat), 32'd0);
    step(1'b1, 1'b0, 8'h0B);
    step(1'b1, 1'b0, 8'h0C);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h0D + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    idle(3);
    chk("t6_beats_after", 32'(m_wr - m_rd), 32'd8);
    chk("t6_pe", 32'(pe_m - pe0), 32'd0);
    mark();
    send_frame(7, 8'hC1, 16, -1);
    idle(3);
    chk("t6n_beats", 32'(m_wr - m_rd), 32'd16);
    check_frame("t6n", 0, 16, 8'hC1, 1'b0);

    // five-byte preamble
    mark();
    send_frame(5, 8'hD1, 8, -1);
    idle(3);
`ifdef STRICT_PREAMBLE_EN
    chk("t7_beats", 32'(m_wr - m_rd), 32'd0);
    chk("t7_pe", 32'(pe_m - pe0), 32'd1);
`else
    chk("t7_beats", 32'(m_wr - m_rd), 32'd8);
    check_frame("t7", 0, 8, 8'hD1, 1'b0);
    chk("t7_pe", 32'(pe_m - pe0), 32'd0);
`endif

    // SFD with no preamble at all
    mark();
    send_frame(0, 8'h11, 4, -1);
    idle(3);
    chk("t8_beats", 32'(m_wr - m_rd), 32'd0);
    chk("t8_pe", 32'(pe_m - pe0), 32'd1);

    // rx_er inside the preamble
    mark();
    step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h55);
    step(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h71 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    idle(3);
    chk("t9_beats", 32'(m_wr - m_rd), 32'd0);
    chk("t9_pe", 32'(pe_m - pe0), 32'd1);

    // 20-byte preamble saturates the counter
    mark();
    send_frame(20, 8'hE1, 4, -1);
    idle(3);
`ifdef STRICT_PREAMBLE_EN
    chk("t10_beats", 32'(m_wr - m_rd), 32'd0);
    chk("t10_pe", 32'(pe_m - pe0), 32'd1);
`else
    chk("t10_beats", 32'(m_wr - m_rd), 32'd4);
    check_frame("t10", 0, 4, 8'hE1, 1'b0);
    chk("t10_pe", 32'(pe_m - pe0), 32'd0);
`endif

    chk("qual_when_idle", 32'(qual_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_preamble_strip.md
Name: rx_preamble_strip

Overview:
- Receive-path stage between the RGMII receiver (GMII-style byte stream) and the CRC-strip stage.
- Detects the 0x55 preamble and the 0xD5 SFD, discards both, and emits frame bytes as a streaming packet interface with start/end-of-packet and error flags.
- The output has no backpressure. It drives the stream_in_* inputs of the CRC-strip stage directly.

Parameters:
- DATA_WIDTH, 8: byte width of rx_data and stream_out_data. Only 8 is supported.
- MIN_PREAMBLE, 1: minimum number of 0x55 bytes required before the SFD. 0 is allowed.
- MAX_FRAME_LEN, 1522: maximum number of post-SFD bytes, FCS included. Longer frames are truncated.

Ports:
- clk, input, 1: receive clock.
- rst_n, input, 1: asynchronous active-low reset.
- rx_dv, input, 1: receive data valid from the RGMII receiver.
- rx_er, input, 1: receive error from the RGMII receiver.
- rx_data, input, DATA_WIDTH: receive byte.
- stream_out_startofpacket, output, 1: first byte after the SFD.
- stream_out_endofpacket, output, 1: last byte of the frame.
- stream_out_valid, output, 1: output byte valid.
- stream_out_data, output, DATA_WIDTH: frame byte.
- stream_out_error, output, 1: frame error, qualified on the EOP beat only.
- preamble_err, output, 1: one-cycle pulse when a frame is discarded before its SFD.

Behaviour:
- Reset: all outputs 0. State = DROP, hold register empty, sticky error and counters cleared.
- States:
  - IDLE: wait for rx_dv=1.
  - PRE: counting preamble bytes.
  - DATA: forwarding frame bytes.
  - DROP: discarding bytes until rx_dv=0.
- IDLE, rx_dv=1:
  - 0x55 → PRE, pre_cnt=1.
  - 0xD5 with MIN_PREAMBLE=0 → DATA.
  - Any other byte → DROP, pulse preamble_err.
- PRE:
  - rx_dv=0 → IDLE silently.
  - rx_er=1 → DROP, pulse preamble_err.
  - 0x55 → pre_cnt increments, saturating at 15.
  - 0xD5 with pre_cnt≥MIN_PREAMBLE → DATA, sop_pending=1.
  - 0xD5 with pre_cnt<MIN_PREAMBLE, or any other byte → DROP, pulse preamble_err.
- DATA (one-byte hold register, used to generate EOP):
  - Each sampled byte with rx_dv=1 goes into the hold register. If the hold register was already full, its previous byte is emitted with eop=0.
  - rx_dv=0 with the hold register full: emit the held byte with eop=1, error=sticky_err. Hold register empties, sticky_err clears, state → IDLE.
  - rx_dv=0 with the hold register empty (SFD followed directly by dv low): nothing is emitted; state → IDLE.
  - sop=1 on the first emitted beat of each frame, then sop_pending clears.
  - A single-byte frame is emitted as one beat with sop=eop=1.
  - rx_er=1 with rx_dv=1 sets sticky_err; that byte is still forwarded.
- Latency: a byte present on rx_data in cycle n appears on stream_out in cycle n+2. All outputs are registered.
- Valid rules:
  - stream_out_valid is high for exactly one cycle per emitted byte.
  - sop/eop/error are 0 whenever valid=0.
  - Output gaps occur only where input gaps occur.
- Length limit:
  - len_cnt (16-bit) counts bytes accepted in DATA.
  - Arrival of byte MAX_FRAME_LEN+1 emits the held byte with eop=1, error=1, and drops the new byte. State → DROP.
- DROP: ignore all input. rx_dv=0 → IDLE.
- Back-to-back frames: a single rx_dv=0 cycle between frames is sufficient. The EOP flush and the next preamble detection are independent.
- Asynchronous reset mid-frame:
  - Outputs clear immediately; no EOP is generated for the interrupted frame.
  - State DROP means the remainder of an in-progress frame is ignored until rx_dv=0.

Optional Feature:
- Macro STRICT_PREAMBLE_EN.
- Defined: the SFD is accepted only when pre_cnt==7 exactly. Any other count → DROP with a preamble_err pulse. MIN_PREAMBLE is ignored.
- Undefined: the MIN_PREAMBLE rule applies; preambles longer than the minimum are accepted.

Test Plan:
- Frame of 7×0x55, 0xD5, 0x01..0x40 (64 bytes), then rx_dv low → 64 beats.
  - Data values 0x01..0x40.
  - sop on 0x01, eop on 0x40, error=0.
  - First beat appears 2 cycles after 0x01 is presented; preamble_err never pulses.
- Frame of 0x55, 0xD5, 0xAB, then dv low → one beat with data 0xAB, sop=eop=1, error=0.
- 64-byte frame with rx_er=1 on byte 10 → all 64 bytes emitted; error=1 on the eop beat only.
- rx_dv high with 0x55, 0x55, 0x12 → preamble_err pulses once, no valid output.
  - A following correct frame after one dv-low cycle is received intact.
- MAX_FRAME_LEN=16, 20-byte frame → 16 beats, eop+error on beat 16, bytes 17–20 discarded.
  - Next frame is normal.
- Assert rst_n low mid-payload, release while rx_dv stays high → no output until dv low.
  - The next full frame is received correctly.
  - With STRICT_PREAMBLE_EN defined, a 5×0x55 preamble → preamble_err pulse and frame dropped.
